// File: rtl/shl_share_arb_if.sv
// shl_share_arb_if
//   Request/response bundle between the requesting sequencers and the shared
//   left-shift unit.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_a/req_sh_amt    : flattened operands, slice i = [i*DATAWIDTH +: DATAWIDTH]
//   rsp_valid/rsp_ready : result handshake toward the consumer
//   rsp_d/rsp_id        : registered shift result and the requester that issued it
//   master = requesters + consumer side, slave = shift unit side.
interface shl_share_arb_if #(
  parameter int DATAWIDTH = 64,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*DATAWIDTH-1:0] req_a;
  logic [NREQ*DATAWIDTH-1:0] req_sh_amt;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATAWIDTH-1:0]      rsp_d;
  logic [IDW-1:0]            rsp_id;

  modport master (
    output req_valid, req_a, req_sh_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_sh_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_id
  );
endinterface

// File: rtl/shl_share_arb.sv
// shl_share_arb
//   One left shifter (d = a << sh_amt, zero fill) shared by NREQ requesters
//   through a round-robin arbiter. The granted result lands in a one-deep
//   output register tagged with the requester ID and is held until the
//   consumer takes it; back-to-back accept/consume gives one result per cycle.
//   Ports:
//     Clk       : rising-edge clock
//     Rst       : asynchronous reset, active-high
//     bus       : shl_share_arb_if.slave (request handshakes, operands, result)
//     busy      : result register occupied (mirror of rsp_valid)
//     grant_cnt : accepted requests since reset, wraps at 2**16
module shl_share_arb #(
  parameter int DATAWIDTH = 64,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  shl_share_arb_if.slave        bus,
  output logic                  busy,
  output logic [15:0]           grant_cnt
);

  localparam logic [DATAWIDTH-1:0] SH_LIMIT = DATAWIDTH'(DATAWIDTH);
  localparam logic [IDW-1:0]       LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       sel;
  logic                 any_req;
  logic                 can_accept;
  logic                 accept;
  logic [NREQ-1:0]      grant_vec;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_sh;

  logic                 vld_p1;
  logic [DATAWIDTH-1:0] d_p1;
  logic [IDW-1:0]       id_p1;

  // Full-width shift amount: anything at or beyond the word width clears the
  // result rather than wrapping the amount.
  function automatic logic [DATAWIDTH-1:0] shl_zero_fill(
    input logic [DATAWIDTH-1:0] a,
    input logic [DATAWIDTH-1:0] sh
  );
    if (sh >= SH_LIMIT) return '0;
    return a << sh;
  endfunction

  // Round-robin search, starting just above the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    sel     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        sel     = IDW'(idx);
      end
    end
  end

  assign can_accept = (state == IDLE) || ((state == HOLD) && bus.rsp_ready);
  assign accept     = any_req && can_accept && !Rst;

  always_comb begin
    grant_vec = '0;
    if (accept) grant_vec[sel] = 1'b1;
  end

  assign sel_a  = bus.req_a[sel*DATAWIDTH +: DATAWIDTH];
  assign sel_sh = bus.req_sh_amt[sel*DATAWIDTH +: DATAWIDTH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: begin
        if (accept)             state_nxt = HOLD;
        else if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered result, tag, pointer and grant counter ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d_p1       <= '0;
      id_p1      <= '0;
      last_grant <= LAST_ID;
      grant_cnt  <= '0;
    end else if (accept) begin
      d_p1       <= shl_zero_fill(sel_a, sel_sh);
      id_p1      <= sel;
      last_grant <= sel;
      grant_cnt  <= grant_cnt + 16'd1;
    end
  end

  assign vld_p1        = (state == HOLD);
  assign bus.req_ready = grant_vec;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_d     = d_p1;
  assign bus.rsp_id    = id_p1;
  assign busy          = vld_p1;

endmodule

// File: tb/tb_shl_share_arb.sv
module tb_shl_share_arb;

  localparam int DW   = 64;
  localparam int NR   = 4;
  localparam int IW   = 2;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] grant_cnt;

  int checks;
  int errors;

  shl_share_arb_if #(.DATAWIDTH(DW), .NREQ(NR), .IDW(IW)) bus ();

  shl_share_arb #(.DATAWIDTH(DW), .NREQ(NR), .IDW(IW)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] sh;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] sh);
    bus.req_a[i*DW +: DW]      = a;
    bus.req_sh_amt[i*DW +: DW] = sh;
  endtask

  initial begin
    logic [3:0] onehot;
    checks = 0;
    errors = 0;

    vecs[0] = '{0, 64'h1,                64'd4,          64'h10};
    vecs[1] = '{1, 64'h0123456789ABCDEF, 64'd0,          64'h0123456789ABCDEF};
    vecs[2] = '{2, 64'h1,                64'd63,         64'h8000000000000000};
    vecs[3] = '{3, 64'hFFFFFFFFFFFFFFFF, 64'd64,         64'h0};
    vecs[4] = '{0, 64'hDEADBEEF,         64'hFFFFFFFFFFFFFFFF, 64'h0};
    vecs[5] = '{1, 64'hFF,               64'd8,          64'hFF00};
    vecs[6] = '{2, 64'hF000000000000001, 64'd4,          64'h10};
    vecs[7] = '{3, 64'h3,                64'd62,         64'hC000000000000000};
    vecs[8] = '{0, 64'h5,                64'h100000000,  64'h0};

    // Reset state, with requests pending while reset is held.
    rst            = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_a      = '0;
    bus.req_sh_amt = '0;
    bus.rsp_ready  = 1'b0;
    #3;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_d",     bus.rsp_d,          64'h0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("rst_grant_cnt", 64'(grant_cnt),     64'h0);
    chk("rst_busy",      64'(busy),          64'h0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    #2 rst = 1'b0;

    // Single-requester transactions covering shift boundaries.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      onehot        = 4'(1 << vecs[i].id);
      bus.req_valid = onehot;
      bus.rsp_ready = 1'b1;
      set_op(vecs[i].id, vecs[i].a, vecs[i].sh);
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(onehot));
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'h1);
      chk($sformatf("v%0d_rsp_d", i),     bus.rsp_d,          vecs[i].exp_d);
      chk($sformatf("v%0d_rsp_id", i),    64'(bus.rsp_id),    64'(vecs[i].id));
      chk($sformatf("v%0d_grant_cnt", i), 64'(grant_cnt),     64'(i + 1));
    end

    // Round robin with all four requesting and the consumer always ready.
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < NR; i++) set_op(i, 64'(i + 1), 64'(i));
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_req_ready", k), 64'(bus.req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr%0d_rsp_id", k), 64'(bus.rsp_id), 64'((k - 1) % 4));
        chk($sformatf("rr%0d_rsp_d", k),  bus.rsp_d, 64'(((k - 1) % 4 + 1) << ((k - 1) % 4)));
      end
      @(posedge clk); #1;
    end

    // Backpressure while holding requester 3's result (4 << 3).
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_req_ready", c), 64'(bus.req_ready), 64'h0);
      chk($sformatf("bp%0d_rsp_valid", c), 64'(bus.rsp_valid), 64'h1);
      chk($sformatf("bp%0d_rsp_id", c),    64'(bus.rsp_id),    64'h3);
      chk($sformatf("bp%0d_rsp_d", c),     bus.rsp_d,          64'd32);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(bus.req_ready), 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_rsp_id",    64'(bus.rsp_id),    64'h1);
    chk("bp_rsp_d",     bus.rsp_d,          64'd4);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("bp_grant_cnt", 64'(grant_cnt),     64'd9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("drain_rsp_d_kept", bus.rsp_d,         64'd4);
    chk("drain_busy",      64'(busy),          64'h0);

    // Reset in the middle of HOLD, with the pointer parked on requester 2.
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("mid_rsp_id",    64'(bus.rsp_id),    64'h2);
    chk("mid_rsp_d",     bus.rsp_d,          64'd12);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("mid_rst_busy",      64'(busy),          64'h0);
    chk("mid_rst_grant_cnt", 64'(grant_cnt),     64'h0);
    chk("mid_rst_rsp_d",     bus.rsp_d,          64'h0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_priority", 64'(bus.req_ready), 64'b0001);

    // Counter wrap: one accept per edge.
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", 64'(grant_cnt), 64'hFFFF);
    @(posedge clk); #1;
    chk("cnt_wrap", 64'(grant_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
